// File: rtl/retospect_neurochip_pkg.sv
// +----------------------------------------------------------------------+
// | neurochip_pkg : sizes, register map and types for the LIF array      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package neurochip_pkg;

  localparam int NUM_NEURONS = 4;
  localparam int V_WIDTH     = 8;
  localparam int W_WIDTH     = 8;
  localparam int REFR_WIDTH  = 4;
  // Worst case |v + 4*w - leak| stays below 1024, so 12 signed bits never overflow.
  localparam int SUM_WIDTH   = 12;

  localparam logic [4:0] ADDR_W_BASE   = 5'h00;
  localparam logic [4:0] ADDR_THR_BASE = 5'h10;
  localparam logic [4:0] ADDR_LEAK     = 5'h14;
  localparam logic [4:0] ADDR_REFR     = 5'h15;

  localparam logic [V_WIDTH-1:0] THR_RESET = 8'd128;

  typedef logic signed [W_WIDTH-1:0] weight_t;

endpackage

`default_nettype wire

// File: rtl/retospect_neurochip_if.sv
// +----------------------------------------------------------------------+
// | retospect_neurochip_if : TinyTapeout tile pin bundle                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface retospect_neurochip_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

`default_nettype wire

// File: rtl/retospect_neurochip_lif_neuron.sv
// +----------------------------------------------------------------------+
// | lif_neuron : one leaky integrate-and-fire neuron with refractory     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lif_neuron
  import neurochip_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_NEURONS-1:0] s,
  input  weight_t               w [NUM_NEURONS],
  input  logic [V_WIDTH-1:0]    thr,
  input  logic [V_WIDTH-1:0]    leak,
  input  logic [REFR_WIDTH-1:0] refr,
  input  logic                  run,
  input  logic                  cfg,
  output logic [V_WIDTH-1:0]    v,
  output logic                  spike
);

  localparam logic signed [SUM_WIDTH-1:0] V_MAX = 12'sd255;

  logic signed [SUM_WIDTH-1:0] sum;
  logic [V_WIDTH-1:0]          v_clamp;
  logic [REFR_WIDTH-1:0]       rcnt;

  always_comb begin
    sum = {{(SUM_WIDTH-V_WIDTH){1'b0}}, v};
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (s[i]) sum = sum + {{(SUM_WIDTH-W_WIDTH){w[i][W_WIDTH-1]}}, w[i]};
    end
    sum = sum - {{(SUM_WIDTH-V_WIDTH){1'b0}}, leak};
    if (sum[SUM_WIDTH-1])  v_clamp = '0;
    else if (sum > V_MAX)  v_clamp = '1;
    else                   v_clamp = sum[V_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      spike <= 1'b0;
      rcnt  <= '0;
    end else if (cfg) begin
      spike <= 1'b0;
    end else if (run) begin
      if (rcnt != '0) begin
        rcnt  <= rcnt - 1'b1;
        v     <= '0;
        spike <= 1'b0;
      end else if (v_clamp >= thr) begin
        spike <= 1'b1;
        v     <= '0;
        rcnt  <= refr;
      end else begin
        spike <= 1'b0;
        v     <= v_clamp;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/retospect_neurochip.sv
// +----------------------------------------------------------------------+
// | retospect_neurochip : 4-neuron LIF array TinyTapeout tile top        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module retospect_neurochip
  import neurochip_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  retospect_neurochip_if.slave bus
);

  logic                   cfg_we;
  logic [4:0]             addr;
  logic                   rec_sel;
  logic [1:0]             probe_sel;
  logic                   run;
  logic                   cfg;
  logic [NUM_NEURONS-1:0] s_ext;
  logic [NUM_NEURONS-1:0] s_in;
  logic [NUM_NEURONS-1:0] spike;

  weight_t                w    [NUM_NEURONS][NUM_NEURONS];
  logic [V_WIDTH-1:0]     thr  [NUM_NEURONS];
  logic [V_WIDTH-1:0]     v    [NUM_NEURONS];
  logic [V_WIDTH-1:0]     leak;
  logic [REFR_WIDTH-1:0]  refr;

  assign cfg_we    = bus.ui_in[7];
  assign addr      = bus.ui_in[4:0];
  assign s_ext     = bus.ui_in[3:0];
  assign rec_sel   = bus.ui_in[4];
  assign probe_sel = bus.ui_in[6:5];
  assign cfg       = bus.ena & cfg_we;
  assign run       = bus.ena & ~cfg_we;
  assign s_in      = rec_sel ? spike : s_ext;

  // Addresses 0x16-0x1F fall through every branch and are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        thr[n] <= THR_RESET;
        for (int i = 0; i < NUM_NEURONS; i++) w[n][i] <= '0;
      end
      leak <= '0;
      refr <= '0;
    end else if (cfg) begin
      if (addr < ADDR_THR_BASE)    w[addr[3:2]][addr[1:0]] <= weight_t'(bus.uio_in);
      else if (addr < ADDR_LEAK)   thr[addr[1:0]] <= bus.uio_in;
      else if (addr == ADDR_LEAK)  leak <= bus.uio_in;
      else if (addr == ADDR_REFR)  refr <= bus.uio_in[REFR_WIDTH-1:0];
    end
  end

  generate
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
      lif_neuron u_neuron (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s_in),
        .w     (w[n]),
        .thr   (thr[n]),
        .leak  (leak),
        .refr  (refr),
        .run   (run),
        .cfg   (cfg),
        .v     (v[n]),
        .spike (spike[n])
      );
    end
  endgenerate

  assign bus.uo_out  = {v[probe_sel][V_WIDTH-1:V_WIDTH-4], spike};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_retospect_neurochip.sv
// +----------------------------------------------------------------------+
// | tb_retospect_neurochip : directed bench with cycle-level LIF model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_retospect_neurochip;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  retospect_neurochip_if bus_i ();

  retospect_neurochip dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  always #5 clk = ~clk;

  // Reference model in plain integers
  int       mw   [4][4];
  int       mthr [4];
  int       mv   [4];
  int       mrc  [4];
  int       mleak;
  int       mrefr;
  bit [3:0] mspk;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      mthr[n] = 128;
      mv[n]   = 0;
      mrc[n]  = 0;
      for (int i = 0; i < 4; i++) mw[n][i] = 0;
    end
    mleak = 0;
    mrefr = 0;
    mspk  = 4'b0000;
  endtask

  task automatic model_step();
    int       a;
    int       sum;
    bit [3:0] sin;
    if (bus_i.ena !== 1'b1) return;
    if (bus_i.ui_in[7]) begin
      a = int'(bus_i.ui_in[4:0]);
      if (a < 16)       mw[a / 4][a % 4] = int'($signed(bus_i.uio_in));
      else if (a < 20)  mthr[a - 16] = int'(bus_i.uio_in);
      else if (a == 20) mleak = int'(bus_i.uio_in);
      else if (a == 21) mrefr = int'(bus_i.uio_in[3:0]);
      mspk = 4'b0000;
      return;
    end
    sin = bus_i.ui_in[4] ? mspk : bus_i.ui_in[3:0];
    for (int n = 0; n < 4; n++) begin
      sum = mv[n] - mleak;
      for (int i = 0; i < 4; i++) if (sin[i]) sum += mw[n][i];
      if (sum < 0)   sum = 0;
      if (sum > 255) sum = 255;
      if (mrc[n] != 0) begin
        mrc[n]--; mv[n] = 0; mspk[n] = 1'b0;
      end else if (sum >= mthr[n]) begin
        mspk[n] = 1'b1; mv[n] = 0; mrc[n] = mrefr;
      end else begin
        mspk[n] = 1'b0; mv[n] = sum;
      end
    end
  endtask

  // Model update and per-cycle comparison
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("spike", {4'h0, bus_i.uo_out[3:0]}, {4'h0, mspk});
    if (bus_i.ui_in[7] == 1'b0)
      check("probe", {4'h0, bus_i.uo_out[7:4]}, 8'(mv[bus_i.ui_in[6:5]] / 16));
    check("uio_out", bus_i.uio_out, 8'h00);
    check("uio_oe", bus_i.uio_oe, 8'h00);
  end

  task automatic tick(bit e, logic [7:0] ui, logic [7:0] d);
    @(negedge clk);
    bus_i.ena    = e;
    bus_i.ui_in  = ui;
    bus_i.uio_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(logic [4:0] a, logic [7:0] d);
    tick(1'b1, {3'b100, a}, d);
  endtask

  task automatic run(logic [3:0] s, bit rec = 1'b0, logic [1:0] p = 2'd0);
    tick(1'b1, {1'b0, p, rec, s}, 8'h00);
  endtask

  initial begin
    logic [7:0] refr_pat [6];
    refr_pat = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    bus_i.ena    = 1'b0;
    bus_i.ui_in  = 8'h00;
    bus_i.uio_in = 8'h00;

    // Reset
    @(posedge clk); #2;
    check("rst_uo", bus_i.uo_out, 8'h00);
    check("rst_oe", bus_i.uio_oe, 8'h00);
    check("rst_uio", bus_i.uio_out, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    run(4'h0); check("idle0", bus_i.uo_out, 8'h00);
    run(4'h0); check("idle1", bus_i.uo_out, 8'h00);

    // Integrate and fire
    wr(5'h00, 8'd40);
    wr(5'h10, 8'd100);
    run(4'b0001); check("int40", bus_i.uo_out, 8'h20);
    run(4'b0001); check("int80", bus_i.uo_out, 8'h50);
    run(4'b0001); check("fire", bus_i.uo_out, 8'h01);
    run(4'b0001); check("after_fire", bus_i.uo_out, 8'h20);

    // Leak and clamp
    wr(5'h14, 8'd3);
    wr(5'h00, 8'd10);
    run(4'b0001); check("leak47", bus_i.uo_out, 8'h20);
    run(4'b0001); check("leak54", bus_i.uo_out, 8'h30);
    run(4'b0000); check("leak51", bus_i.uo_out, 8'h30);
    repeat (19) run(4'b0000);
    check("floor0", bus_i.uo_out, 8'h00);
    wr(5'h14, 8'd0);
    run(4'b0001);
    run(4'b0001); check("v20", bus_i.uo_out, 8'h10);
    wr(5'h01, 8'h80);
    run(4'b0010); check("neg_clamp", bus_i.uo_out, 8'h00);

    // Refractory
    wr(5'h15, 8'd2);
    wr(5'h00, 8'd50);
    wr(5'h10, 8'd50);
    for (int k = 0; k < 6; k++) begin
      run(4'b0001);
      check("refr_pat", bus_i.uo_out, refr_pat[k]);
    end

    // Recurrent hop 0 -> 1
    wr(5'h15, 8'd0);
    wr(5'h00, 8'd0);
    wr(5'h01, 8'd0);
    wr(5'h03, 8'd60);
    wr(5'h10, 8'd60);
    wr(5'h04, 8'd60);
    wr(5'h11, 8'd60);
    run(4'b1000, 1'b0, 2'd0); check("rec_hop0", bus_i.uo_out, 8'h01);
    run(4'b0000, 1'b1, 2'd1); check("rec_hop1", bus_i.uo_out, 8'h02);
    run(4'b0000, 1'b1, 2'd0); check("rec_hop2", bus_i.uo_out, 8'h00);

    // Freeze and config-hold
    wr(5'h03, 8'd0);
    wr(5'h04, 8'd0);
    wr(5'h00, 8'd40);
    wr(5'h10, 8'd100);
    run(4'b0001); check("frz_v40", bus_i.uo_out, 8'h20);
    tick(1'b0, 8'h01, 8'h00); check("frz_hold", bus_i.uo_out, 8'h20);
    tick(1'b0, 8'h90, 8'd5);  check("frz_cfg", {4'h0, bus_i.uo_out[3:0]}, 8'h00);
    run(4'b0001); check("frz_v80", bus_i.uo_out, 8'h50);
    run(4'b0001); check("frz_fire", bus_i.uo_out, 8'h01);
    wr(5'h16, 8'hFF); check("cfg_clr", {4'h0, bus_i.uo_out[3:0]}, 8'h00);
    run(4'b0001); check("cfg_v40", bus_i.uo_out, 8'h20);
    wr(5'h17, 8'h00);
    run(4'b0000); check("cfg_held", bus_i.uo_out, 8'h20);

    // Asynchronous reset mid-run
    run(4'b0001); check("pre_rst", bus_i.uo_out, 8'h50);
    #1 rst_n = 1'b0;
    #1 check("async_rst", bus_i.uo_out, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    run(4'b0001); check("rst_w0", bus_i.uo_out, 8'h00);
    run(4'b0000); check("rst_idle", bus_i.uo_out, 8'h00);

    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
